// File: rtl/sv_latch_share_arbiter.sv
// sv_latch_share_arbiter: round-robin sharing of one capture register, held until out_ack or timeout
module sv_latch_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    clear,
    output logic                    latch_en,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(NREQ)-1:0] out_src,
    input  logic                    out_ack,
    output logic                    timeout_err
);
    localparam int IW   = $clog2(NREQ);
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_q, rr_d, src_q, src_d, win;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, found, expire;
    logic [WIDTH-1:0] data_q, data_d;
    int unsigned      idx;

    // First requesting index at or above rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign expire = (TIMEOUT != 0) && (cnt_q == CW'(TLIM));

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        data_d      = data_q;
        src_d       = src_q;
        req_ready   = '0;
        latch_en    = 1'b0;
        timeout_err = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            data_d  = '0;
        end else if (state_q == IDLE) begin
            if (found) begin
                req_ready[win] = 1'b1;
                latch_en       = 1'b1;
                data_d         = req_data[int'(win)*WIDTH +: WIDTH];
                src_d          = win;
                valid_d        = 1'b1;
                rr_d           = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                state_d        = HOLD;
            end
        end else if (out_ack || expire) begin
            timeout_err = !out_ack;
            state_d     = IDLE;
            valid_d     = 1'b0;
            cnt_d       = '0;
        end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        end
        // Reset overrides the combinational strobes in the cycle it is sampled.
        if (reset) begin
            req_ready   = '0;
            latch_en    = 1'b0;
            timeout_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;
endmodule

// File: tb/tb_sv_latch_share_arbiter.sv
// tb_sv_latch_share_arbiter: directed checks of grant order, hold, ack, timeout, clear and reset
module tb_sv_latch_share_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        clear = 1'b0;
    logic        latch_en, out_valid, timeout_err;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ack = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    sv_latch_share_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .clear(clear), .latch_en(latch_en),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ack(out_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
        n_checks++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", out_src); end
        n_checks++; if (req_ready !== 4'b0000 || latch_en !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: ready=%b latch=%b terr=%b want 0000/0/0", req_ready, latch_en, timeout_err);
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        req_valid = 4'b0001; req_data[7:0] = 8'hA5;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        n_checks++; if (latch_en !== 1'b1) begin n_fail++; $display("FAIL single_latch: got %b want 1", latch_en); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd0) begin
            n_fail++; $display("FAIL single_capture: valid=%b data=%h src=%0d want 1/a5/0", out_valid, out_data, out_src);
        end
        n_checks++; if (latch_en !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_hold_strobes: latch=%b ready=%b want 0/0000", latch_en, req_ready); end
        @(negedge clk);
        @(negedge clk);
        out_ack = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_at_ack: got %b want 1", out_valid); end
        @(negedge clk);
        out_ack = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            n_fail++; $display("FAIL single_release: valid=%b data=%h want 0/a5", out_valid, out_data);
        end
    endtask

    task automatic test_round_robin;
        int e;
        @(negedge clk);
        req_valid = 4'b1111; req_data = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            e = (1 + i) % 4;
            #1;
            n_checks++; if (req_ready !== 4'(1 << e) || latch_en !== 1'b1) begin
                n_fail++; $display("FAIL rr_grant_%0d: ready=%b latch=%b want %b/1", i, req_ready, latch_en, 4'(1 << e));
            end
            @(negedge clk);
            out_ack = 1'b1;
            #1;
            n_checks++; if (out_valid !== 1'b1 || out_src !== 2'(e) || out_data !== 8'(8'h11 * (e + 1))) begin
                n_fail++; $display("FAIL rr_word_%0d: valid=%b src=%0d data=%h want 1/%0d/%h", i, out_valid, out_src, out_data, e, 8'(8'h11 * (e + 1)));
            end
            @(negedge clk);
            out_ack = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout;
        @(negedge clk);
        req_valid = 4'b0100; req_data[23:16] = 8'h3C;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL to_grant: got %b want 0100", req_ready); end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            n_checks++; if (timeout_err !== (k == 15) || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL to_hold_%0d: terr=%b valid=%b want %b/1", k, timeout_err, out_valid, k == 15);
            end
        end
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        n_checks++; if (out_valid !== 1'b0 || timeout_err !== 1'b0 || out_data !== 8'h3C) begin
            n_fail++; $display("FAIL to_release: valid=%b terr=%b data=%h want 0/0/3c", out_valid, timeout_err, out_data);
        end
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL to_next_grant: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0; out_ack = 1'b1;
        #1;
        n_checks++; if (out_src !== 2'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL to_next_src: src=%0d valid=%b want 3/1", out_src, out_valid); end
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    task automatic test_clear;
        @(negedge clk);
        req_valid = 4'b0001; req_data[7:0] = 8'h5A;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL clr_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010; clear = 1'b1;
        #1;
        n_checks++; if (out_data !== 8'h5A || out_valid !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL clr_hold: data=%h valid=%b ready=%b want 5a/1/0000", out_data, out_valid, req_ready);
        end
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_checks++; if (out_data !== 8'h00 || out_valid !== 1'b0 || out_src !== 2'd0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL clr_after: data=%h valid=%b src=%0d terr=%b want 00/0/0/0", out_data, out_valid, out_src, timeout_err);
        end
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL clr_regrant: got %b want 0010", req_ready); end
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_checks++; if (out_src !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_src1: src=%0d valid=%b want 1/1", out_src, out_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || req_ready !== 4'b0000 || latch_en !== 1'b0) begin
            n_fail++; $display("FAIL clr_idle_block: valid=%b ready=%b latch=%b want 0/0000/0", out_valid, req_ready, latch_en);
        end
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL clr_idle_regrant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_reset_mid_hold;
        @(negedge clk);
        reset = 1'b1; req_valid = 4'b1000;
        #1;
        n_checks++; if (out_valid !== 1'b1 || req_ready !== 4'b0000 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold: valid=%b ready=%b terr=%b want 1/0000/0", out_valid, req_ready, timeout_err);
        end
        @(negedge clk);
        reset = 1'b0; req_valid = 4'b1010;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            n_fail++; $display("FAIL rst_outputs: valid=%b data=%h src=%0d want 0/00/0", out_valid, out_data, out_src);
        end
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_ptr_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000; out_ack = 1'b1;
        #1;
        n_checks++; if (out_src !== 2'd1) begin n_fail++; $display("FAIL rst_src: got %0d want 1", out_src); end
        @(negedge clk);
        out_ack = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rst_req3_grant: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0; out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    task automatic test_ack_at_timeout;
        @(negedge clk);
        req_valid = 4'b0001; req_data[7:0] = 8'h77;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ackto_grant: got %b want 0001", req_ready); end
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            req_valid = '0;
            out_ack = (k == 15);
            #1;
            n_checks++; if (timeout_err !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL ackto_hold_%0d: terr=%b valid=%b want 0/1", k, timeout_err, out_valid);
            end
        end
        @(negedge clk);
        out_ack = 1'b0; req_valid = 4'b0100;
        #1;
        n_checks++; if (out_valid !== 1'b0 || timeout_err !== 1'b0 || out_data !== 8'h77) begin
            n_fail++; $display("FAIL ackto_release: valid=%b terr=%b data=%h want 0/0/77", out_valid, timeout_err, out_data);
        end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL ackto_regrant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_clear();
        test_reset_mid_hold();
        test_ack_at_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
